mem_access_stage: RTL

EXE/MEM pipeline stage directly downstream of the ALU. It registers the ALU result and destination tag, and turns load/store instructions into a single-outstanding data-memory request with byte-lane alignment. It waits on a ready handshake, stalling the EXE stage meanwhile. It then delivers the write-back value (ALU result or extended load data) to the WB stage.

---
 rtl/mem_access_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: EXE/MEM stage issuing one outstanding aligned load/store and delivering write-back results.
// Ports: clk/rst (async, active-high); EXE side alu_result, rs2_data, opcode_EXE, funct3_EXE, rd_EXE,
// reg_write_EXE, valid_EXE, flush, stall_EXE; memory side mem_req, mem_we, mem_addr, mem_wdata,
// mem_ready, mem_rdata; WB side result_MEM, rd_MEM, reg_write_MEM, valid_MEM; misalign_exc pulse.
module mem_access_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic [6:0]        opcode_EXE,
  input  logic [2:0]        funct3_EXE,
  input  logic [4:0]        rd_EXE,
  input  logic              reg_write_EXE,
  input  logic              valid_EXE,
  input  logic              flush,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic [3:0]        mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall_EXE,
  output logic [DATA_W-1:0] result_MEM,
  output logic [4:0]        rd_MEM,
  output logic              reg_write_MEM,
  output logic              valid_MEM,
  output logic              misalign_exc
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] ACCESS   = 1'b1;
  logic [0:0]        r_state;
  logic              r_req;
  logic [3:0]        r_we;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_result;
  logic [4:0]        r_rd_mem;
  logic              r_rw_mem;
  logic              r_valid;
  logic              r_exc;
  logic [1:0]        r_off;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic              r_rw;
  logic              r_is_load;
  logic              w_acc;
  logic              w_load;
  logic              w_store;
  logic              w_mem;
  logic              w_legal;
  logic              w_mis;
  logic [3:0]        w_we;
  logic [DATA_W-1:0] w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ld;
  assign w_acc   = valid_EXE & ~flush;
  assign w_load  = opcode_EXE == OP_LOAD;
  assign w_store = opcode_EXE == OP_STORE;
  assign w_mem   = w_load | w_store;
  // loads reject 011/110/111, stores reject anything above SW
  assign w_legal = w_load ? (funct3_EXE != 3'b011 && funct3_EXE[2:1] != 2'b11) : (funct3_EXE < 3'b011);
  // funct3[1] marks a word access, funct3[0] a halfword (signed or unsigned)
  assign w_mis   = funct3_EXE[1] ? |alu_result[1:0] : funct3_EXE[0] & alu_result[0];
  assign w_we    = !w_store ? 4'b0000 :
                   funct3_EXE[1] ? 4'b1111 :
                   funct3_EXE[0] ? 4'b0011 << {alu_result[1], 1'b0} :
                   4'b0001 << alu_result[1:0];
  assign w_wdata = funct3_EXE[1] ? rs2_data :
                   funct3_EXE[0] ? {2{rs2_data[15:0]}} : {4{rs2_data[7:0]}};
  assign w_byte  = mem_rdata[{r_off, 3'b000} +: 8];
  assign w_half  = mem_rdata[{r_off[1], 4'b0000} +: 16];
  // funct3[2] selects zero extension (LBU/LHU)
  assign w_ld    = r_f3[1] ? mem_rdata :
                   r_f3[0] ? {{16{~r_f3[2] & w_half[15]}}, w_half} :
                   {{24{~r_f3[2] & w_byte[7]}}, w_byte};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_we      <= 4'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_result  <= '0;
      r_rd_mem  <= 5'b0;
      r_rw_mem  <= 1'b0;
      r_valid   <= 1'b0;
      r_exc     <= 1'b0;
      r_off     <= 2'b0;
      r_f3      <= 3'b0;
      r_rd      <= 5'b0;
      r_rw      <= 1'b0;
      r_is_load <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_exc   <= 1'b0;
      if (r_state == IDLE) begin
        if (w_acc && !w_mem) begin
          r_result <= alu_result;
          r_rd_mem <= rd_EXE;
          r_rw_mem <= reg_write_EXE;
          r_valid  <= 1'b1;
        end else if (w_acc && w_legal && w_mis) begin
          r_exc <= 1'b1;
        end else if (w_acc && w_legal) begin
          r_state   <= ACCESS;
          r_req     <= 1'b1;
          r_addr    <= {alu_result[DATA_W-1:2], 2'b00};
          r_we      <= w_we;
          r_wdata   <= w_wdata;
          r_off     <= alu_result[1:0];
          r_f3      <= funct3_EXE;
          r_rd      <= rd_EXE;
          r_rw      <= reg_write_EXE;
          r_is_load <= w_load;
        end
      end else if (mem_ready) begin
        r_state  <= IDLE;
        r_req    <= 1'b0;
        r_we     <= 4'b0;
        r_valid  <= 1'b1;
        r_rd_mem <= r_rd;
        r_rw_mem <= r_is_load & r_rw;
        if (r_is_load) r_result <= w_ld;
      end
    end
  end
  assign stall_EXE     = r_state == ACCESS;
  assign mem_req       = r_req;
  assign mem_we        = r_we;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign result_MEM    = r_result;
  assign rd_MEM        = r_rd_mem;
  assign reg_write_MEM = r_rw_mem;
  assign valid_MEM     = r_valid;
  assign misalign_exc  = r_exc;
endmodule
